dev_exec: RTL

Execution stage directly downstream of the device instruction fetch: consumes the 32-bit instruction words fetched from device memory and executes them. Holds a 16x8 register file and accesses the shared 16K-byte device memory through a req/ack byte port. Reports halt/error status and a retired-instruction count to the command interpreter's register space.

---
 rtl/dev_pkg.sv | 37 +++
 rtl/dev_regfile.sv | 39 +++
 rtl/dev_exec.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/dev_pkg.sv
// Shared definitions for the device execution stage: instruction layout,
// opcodes, FSM states and default sizes.
package dev_pkg;

  localparam int unsigned DefAddrBits = 14;
  localparam int unsigned DefNumRegs  = 16;
  localparam int unsigned DefCntBits  = 16;

  // Instruction field positions (low bit of each field)
  localparam int unsigned OpLsb   = 28;
  localparam int unsigned RdLsb   = 24;
  localparam int unsigned RsLsb   = 20;
  localparam int unsigned RtLsb   = 16;
  localparam int unsigned AddrLsb = 0;
  localparam int unsigned ImmLsb  = 0;

  // Opcodes 8-15 are illegal and halt the stage with an error
  typedef enum logic [3:0] {
    OpNop  = 4'd0,
    OpLdi  = 4'd1,
    OpAdd  = 4'd2,
    OpSub  = 4'd3,
    OpLd   = 4'd4,
    OpSt   = 4'd5,
    OpBnz  = 4'd6,
    OpHalt = 4'd7
  } opcode_e;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StExec   = 3'd1,
    StMem    = 3'd2,
    StBranch = 3'd3,
    StHalted = 3'd4
  } state_e;

endpackage

// File: rtl/dev_regfile.sv
// 8-bit register file: three asynchronous read ports, one synchronous write
// port, synchronous clear on reset.
module dev_regfile
  import dev_pkg::*;
#(
  parameter int unsigned NumRegs = DefNumRegs
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] ra_addr_i,
  output logic [7:0] ra_data_o,
  input  logic [3:0] rb_addr_i,
  output logic [7:0] rb_data_o,
  input  logic [3:0] rc_addr_i,
  output logic [7:0] rc_data_o,
  input  logic       we_i,
  input  logic [3:0] wa_i,
  input  logic [7:0] wd_i
);

  logic [7:0] regs_q [NumRegs];

  // Register storage: clear on reset, single write per cycle
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  // Reads see the pre-write value during a write cycle
  assign ra_data_o = regs_q[ra_addr_i];
  assign rb_data_o = regs_q[rb_addr_i];
  assign rc_data_o = regs_q[rc_addr_i];

endmodule

// File: rtl/dev_exec.sv
// Device execution stage: accepts 32-bit instruction words, executes ALU,
// memory and branch ops against a 16x8 register file, and reports status.
module dev_exec
  import dev_pkg::*;
#(
  parameter int unsigned ADDR_BITS = DefAddrBits,
  parameter int unsigned NUM_REGS  = DefNumRegs,
  parameter int unsigned CNT_BITS  = DefCntBits
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_en,
  input  logic                 i_inst_valid,
  input  logic [31:0]          i_inst,
  output logic                 o_inst_ready,
  output logic                 o_branch_valid,
  output logic [7:0]           o_branch_target,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [ADDR_BITS-1:0] o_mem_addr,
  output logic [7:0]           o_mem_wdata,
  input  logic [7:0]           i_mem_rdata,
  input  logic                 i_mem_ack,
  output logic                 o_busy,
  output logic                 o_halted,
  output logic                 o_error,
  output logic [CNT_BITS-1:0]  o_retired,
  input  logic [3:0]           i_dbg_sel,
  output logic [7:0]           o_dbg_data
);

  state_e               state_q, state_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]           ld_rd_q, ld_rd_d;
  logic [7:0]           br_target_q, br_target_d;
  logic                 err_q, err_d;
  logic [CNT_BITS-1:0]  retired_q, retired_d;

  opcode_e    op;
  logic [3:0] rd, rs, rt, rb_addr;
  logic [7:0] imm;
  logic [7:0] ra_data, rb_data;
  logic       inst_ready, accept, retire, mem_req;
  logic       rf_we;
  logic [3:0] rf_wa;
  logic [7:0] rf_wd;
  logic       unused_inst;

  assign op  = opcode_e'(i_inst[OpLsb +: 4]);
  assign rd  = i_inst[RdLsb +: 4];
  assign rs  = i_inst[RsLsb +: 4];
  assign rt  = i_inst[RtLsb +: 4];
  assign imm = i_inst[ImmLsb +: 8];
  assign unused_inst = ^i_inst[15:14];

  // ST and BNZ read r[rd] and never need rt, so they share the second port
  assign rb_addr = ((op == OpSt) || (op == OpBnz)) ? rd : rt;

  assign inst_ready = ((state_q == StIdle) || (state_q == StExec)) && i_en;
  assign accept     = inst_ready && i_inst_valid;
  assign mem_req    = (state_q == StMem);

  dev_regfile #(
    .NumRegs (NUM_REGS)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .ra_addr_i (rs),
    .ra_data_o (ra_data),
    .rb_addr_i (rb_addr),
    .rb_data_o (rb_data),
    .rc_addr_i (i_dbg_sel),
    .rc_data_o (o_dbg_data),
    .we_i      (rf_we),
    .wa_i      (rf_wa),
    .wd_i      (rf_wd)
  );

  // Next-state decode: instruction dispatch, memory handshake, halt/exit
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ld_rd_d     = ld_rd_q;
    br_target_d = br_target_q;
    err_d       = err_q;
    rf_we       = 1'b0;
    rf_wa       = rd;
    rf_wd       = '0;
    retire      = 1'b0;
    unique case (state_q)
      StIdle, StExec: begin
        state_d = StIdle;
        if (accept) begin
          case (op)
            OpNop: begin
              state_d = StExec;
              retire  = 1'b1;
            end
            OpLdi: begin
              rf_we   = 1'b1;
              rf_wd   = imm;
              state_d = StExec;
              retire  = 1'b1;
            end
            OpAdd: begin
              rf_we   = 1'b1;
              rf_wd   = ra_data + rb_data;
              state_d = StExec;
              retire  = 1'b1;
            end
            OpSub: begin
              rf_we   = 1'b1;
              rf_wd   = ra_data - rb_data;
              state_d = StExec;
              retire  = 1'b1;
            end
            OpLd: begin
              state_d    = StMem;
              mem_we_d   = 1'b0;
              mem_addr_d = i_inst[AddrLsb +: ADDR_BITS];
              ld_rd_d    = rd;
            end
            OpSt: begin
              state_d     = StMem;
              mem_we_d    = 1'b1;
              mem_addr_d  = i_inst[AddrLsb +: ADDR_BITS];
              mem_wdata_d = rb_data;
            end
            OpBnz: begin
              retire = 1'b1;
              if (rb_data != 8'd0) begin
                state_d     = StBranch;
                br_target_d = imm;
              end else begin
                state_d = StExec;
              end
            end
            OpHalt: begin
              retire  = 1'b1;
              state_d = StHalted;
            end
            default: begin
              state_d = StHalted;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StMem: begin
        // Retires on ack; enable is deliberately not sampled here
        if (i_mem_ack) begin
          state_d = StIdle;
          retire  = 1'b1;
          if (!mem_we_q) begin
            rf_we = 1'b1;
            rf_wa = ld_rd_q;
            rf_wd = i_mem_rdata;
          end
        end
      end
      StBranch: begin
        state_d = StIdle;
      end
      StHalted: begin
        if (!i_en) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Saturating retired-instruction counter
  always_comb begin
    retired_d = retired_q;
    if (retire && (retired_q != '1)) begin
      retired_d = retired_q + CNT_BITS'(1);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= StIdle;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ld_rd_q     <= '0;
      br_target_q <= '0;
      err_q       <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ld_rd_q     <= ld_rd_d;
      br_target_q <= br_target_d;
      err_q       <= err_d;
      retired_q   <= retired_d;
    end
  end

  // Outputs: memory and branch fields are zero outside their active states
  always_comb begin
    o_inst_ready    = inst_ready;
    o_mem_req       = mem_req;
    o_mem_we        = mem_req && mem_we_q;
    o_mem_addr      = mem_req ? mem_addr_q : '0;
    o_mem_wdata     = (mem_req && mem_we_q) ? mem_wdata_q : '0;
    o_branch_valid  = (state_q == StBranch);
    o_branch_target = (state_q == StBranch) ? br_target_q : '0;
    o_busy          = (state_q != StIdle) && (state_q != StHalted);
    o_halted        = (state_q == StHalted);
    o_error         = err_q;
    o_retired       = retired_q;
  end

endmodule
